fire9_squeeze_ofm_writer: RTL and testbench

//  Consumer end of the fire9Squeeze sample/ram_feedback interface.
//  - Captures the DSP_NO-wide ofm vector on each fire9Squeeze_sample pulse.
//  - Serialises the vector into the output feature-map RAM, one word per clock,

---
 rtl/fire9_squeeze_ofm_writer.sv | 123 ++++++++++++
 tb/tb_fire9_squeeze_ofm_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fire9_squeeze_ofm_writer.sv
// Consumer end of the fire9Squeeze sample/ram_feedback link: captures each ofm
// vector and writes it word by word into the output feature-map RAM.
module fire9_squeeze_ofm_writer #(
  parameter int unsigned WOUT      = 8,
  parameter int unsigned DSP_NO    = 112,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned AW        = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ofm_sample,
  input  logic [WIDTH*DSP_NO-1:0] ofm_vec,
  output logic                    ram_wr_en,
  output logic [AW-1:0]           ram_wr_addr,
  output logic [WIDTH-1:0]        ram_wr_data,
  output logic                    ram_feedback,
  output logic                    busy,
  output logic                    overflow_err
);

  localparam int unsigned NPIX = WOUT * WOUT;
  localparam int unsigned CW   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int unsigned PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] CH_LAST  = CW'(DSP_NO - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [AW-1:0] BASE_A   = AW'(BASE_ADDR);
  localparam logic [AW-1:0] DSP_A    = AW'(DSP_NO);

  logic [1:0]              state_q, state_nxt;
  logic [CW-1:0]           ch_q, ch_nxt;
  logic [PW-1:0]           pix_q, pix_nxt;
  logic [WIDTH*DSP_NO-1:0] vec_q;
  logic                    load_c;
  logic                    wr_en_nxt, fb_nxt, busy_nxt, ovf_nxt;
  logic [AW-1:0]           addr_nxt;
  logic [WIDTH-1:0]        data_nxt;

  // Next-state, counter and output-register decode
  always_comb begin
    state_nxt = state_q;
    ch_nxt    = ch_q;
    pix_nxt   = pix_q;
    load_c    = 1'b0;
    wr_en_nxt = 1'b0;
    fb_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    ovf_nxt   = overflow_err;
    addr_nxt  = ram_wr_addr;
    data_nxt  = ram_wr_data;
    case (state_q)
      IDLE: begin
        if (ofm_sample) begin
          load_c    = 1'b1;
          ch_nxt    = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        wr_en_nxt = 1'b1;
        busy_nxt  = 1'b1;
        addr_nxt  = BASE_A + AW'(pix_q) * DSP_A + AW'(ch_q);
        data_nxt  = vec_q[32'(ch_q) * WIDTH +: WIDTH];
        if (ch_q == CH_LAST) begin
          ch_nxt = '0;
          if (pix_q == PIX_LAST) begin
            // Final word of the layer: counters wrap here and only here
            pix_nxt   = '0;
            state_nxt = DONE;
            if (ofm_sample) ovf_nxt = 1'b1;
          end else begin
            pix_nxt = pix_q + PW'(1);
            if (ofm_sample) load_c = 1'b1;
            else            state_nxt = IDLE;
          end
        end else begin
          ch_nxt = ch_q + CW'(1);
          if (ofm_sample) ovf_nxt = 1'b1;
        end
      end
      DONE: begin
        fb_nxt = 1'b1;
        if (ofm_sample) ovf_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      pix_q        <= '0;
      ram_wr_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_wr_data  <= '0;
      ram_feedback <= 1'b0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      ch_q         <= ch_nxt;
      pix_q        <= pix_nxt;
      ram_wr_en    <= wr_en_nxt;
      ram_wr_addr  <= addr_nxt;
      ram_wr_data  <= data_nxt;
      ram_feedback <= fb_nxt;
      busy         <= busy_nxt;
      overflow_err <= ovf_nxt;
    end
  end

  // Capture buffer needs no reset; its contents only matter after a load
  always_ff @(posedge clk) begin
    if (load_c) vec_q <= ofm_vec;
  end

endmodule

// File: tb/tb_fire9_squeeze_ofm_writer.sv
// Randomised bench for fire9_squeeze_ofm_writer: a schedule of expected RAM
// writes per cycle is built from each pulse and checked every cycle.
module tb_fire9_squeeze_ofm_writer;

  localparam int unsigned WOUT = 8, DSP_NO = 112, WIDTH = 16, AW = 13;
  localparam int unsigned NPIX = WOUT * WOUT, VW = WIDTH * DSP_NO;
  localparam int BIG = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic s0, s1;
  logic [VW-1:0] v0, v1;
  logic en0, en1, fb0, fb1, bz0, bz1, ov0, ov1;
  logic [AW-1:0] ad0, ad1;
  logic [WIDTH-1:0] dt0, dt1;

  fire9_squeeze_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH),
    .BASE_ADDR(0), .AW(AW)) dut0 (
    .clk(clk), .rst(rst), .ofm_sample(s0), .ofm_vec(v0),
    .ram_wr_en(en0), .ram_wr_addr(ad0), .ram_wr_data(dt0),
    .ram_feedback(fb0), .busy(bz0), .overflow_err(ov0));

  fire9_squeeze_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH),
    .BASE_ADDR(1024), .AW(AW)) dut1 (
    .clk(clk), .rst(rst), .ofm_sample(s1), .ofm_vec(v1),
    .ram_wr_en(en1), .ram_wr_addr(ad1), .ram_wr_data(dt1),
    .ram_feedback(fb1), .busy(bz1), .overflow_err(ov1));

  // Reference model: per-cycle expected writes plus event times
  logic [31:0] sched [longint];
  int cyc;
  int busy_until [2];
  int pixels [2];
  int done_cyc [2];
  int ovf_cyc [2];
  int base [2];
  int wr_cnt [2];
  int min_ad [2];
  int max_ad [2];
  int n_cmp, n_bad;

  function automatic longint key(input int d, input int c);
    return longint'(d) * 64'd1000000 + longint'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic en, input logic [AW-1:0] ad,
                         input logic [WIDTH-1:0] dt, input logic fb, input logic bz,
                         input logic ov);
    longint k = key(d, cyc);
    logic e = sched.exists(k);
    logic [31:0] w;
    chk($sformatf("d%0d wr_en c%0d", d, cyc), 32'(en), 32'(e));
    chk($sformatf("d%0d busy c%0d", d, cyc), 32'(bz), 32'(e));
    if (e) begin
      w = sched[k];
      chk($sformatf("d%0d addr c%0d", d, cyc), 32'(ad), 32'(w[28:16]));
      chk($sformatf("d%0d data c%0d", d, cyc), 32'(dt), 32'(w[15:0]));
    end
    chk($sformatf("d%0d feedback c%0d", d, cyc), 32'(fb), 32'(cyc >= done_cyc[d]));
    chk($sformatf("d%0d overflow c%0d", d, cyc), 32'(ov), 32'(cyc >= ovf_cyc[d]));
    if (en) begin
      wr_cnt[d]++;
      if (int'(ad) < min_ad[d]) min_ad[d] = int'(ad);
      if (int'(ad) > max_ad[d]) max_ad[d] = int'(ad);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk_dut(0, en0, ad0, dt0, fb0, bz0, ov0);
      chk_dut(1, en1, ad1, dt1, fb1, bz1, ov1);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int c = cyc + 1; c <= busy_until[d] + 1; c++)
        if (sched.exists(key(d, c))) sched.delete(key(d, c));
      busy_until[d] = 0;
      pixels[d]     = 0;
      done_cyc[d]   = BIG;
      ovf_cyc[d]    = BIG;
      wr_cnt[d]     = 0;
      min_ad[d]     = BIG;
      max_ad[d]     = 0;
    end
  endtask

  // Asynchronous reset: writes must stop immediately
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst wr_en0", 32'(en0), 32'd0);
    chk("rst busy0", 32'(bz0), 32'd0);
    chk("rst ovf0", 32'(ov0), 32'd0);
    chk("rst fb1", 32'(fb1), 32'd0);
    model_clear();
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // One ofm_sample pulse on dut d, sampled at the next rising edge
  task automatic pulse(input int d, input bit ramp);
    logic [VW-1:0] v;
    logic [WIDTH-1:0] lane;
    int s = cyc + 1;
    bit acc = (pixels[d] < int'(NPIX)) && (s >= busy_until[d]);
    for (int k = 0; k < int'(DSP_NO); k++) begin
      lane = ramp ? WIDTH'(k + 1) : WIDTH'($urandom);
      v[k*WIDTH +: WIDTH] = lane;
      if (acc)
        sched[key(d, s + 1 + k)] = {3'b000, AW'(base[d] + pixels[d] * int'(DSP_NO) + k), lane};
    end
    if (acc) begin
      busy_until[d] = s + int'(DSP_NO);
      pixels[d]++;
      if (pixels[d] == int'(NPIX)) done_cyc[d] = s + int'(DSP_NO) + 1;
    end else if (s < ovf_cyc[d]) begin
      ovf_cyc[d] = s;
    end
    if (d == 0) begin s0 = 1'b1; v0 = v; end
    else        begin s1 = 1'b1; v1 = v; end
    step(1);
    s0 = 1'b0;
    s1 = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    base[0] = 0; base[1] = 1024;
    busy_until[0] = 0; busy_until[1] = 0;
    rst = 1'b1; s0 = 1'b0; s1 = 1'b0; v0 = '0; v1 = '0;
    model_clear();
    step(2);
    rst = 1'b0;
    step(1);

    // Single ramp vector: addr 0..111, data 1..112
    pulse(0, 1'b1);
    step(120);
    chk("t1 write count", 32'(wr_cnt[0]), 32'd112);
    chk("t1 max addr", 32'(max_ad[0]), 32'd111);

    // Pulse mid-drain is dropped
    do_reset();
    pulse(0, 1'b0);
    step(49);
    pulse(0, 1'b0);
    step(80);
    chk("t3 overflow", 32'(ov0), 32'd1);
    chk("t3 write count", 32'(wr_cnt[0]), 32'd112);

    // Pulse on the last-word cycle is accepted without a gap
    do_reset();
    pulse(0, 1'b0);
    step(111);
    pulse(0, 1'b0);
    step(120);
    chk("t4 overflow", 32'(ov0), 32'd0);
    chk("t4 write count", 32'(wr_cnt[0]), 32'd224);

    // Reset at channel 40 of pixel 3, then restart from addr 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1'b0);
      step(111);
    end
    pulse(0, 1'b0);
    step(41);
    chk("t5 addr before rst", 32'(ad0), 32'd376);
    do_reset();
    pulse(0, 1'b0);
    step(115);
    chk("t5 restart count", 32'(wr_cnt[0]), 32'd112);
    chk("t5 restart min addr", 32'(min_ad[0]), 32'd0);

    // Full layer at 513-cycle spacing
    do_reset();
    for (int i = 0; i < int'(NPIX); i++) begin
      pulse(0, 1'b0);
      step(512);
    end
    chk("t2 write count", 32'(wr_cnt[0]), 32'd7168);
    chk("t2 last addr", 32'(max_ad[0]), 32'd7167);
    chk("t2 feedback", 32'(fb0), 32'd1);
    chk("t2 overflow", 32'(ov0), 32'd0);

    // Back-to-back layer at base 1024, then a pulse after feedback
    do_reset();
    for (int i = 0; i < int'(NPIX); i++) begin
      pulse(1, 1'b0);
      step(111);
    end
    step(5);
    chk("t6 feedback", 32'(fb1), 32'd1);
    chk("t6 overflow before", 32'(ov1), 32'd0);
    pulse(1, 1'b0);
    step(5);
    chk("t6 overflow after", 32'(ov1), 32'd1);
    chk("t6 write count", 32'(wr_cnt[1]), 32'd7168);
    chk("t6 min addr", 32'(min_ad[1]), 32'd1024);
    chk("t6 max addr", 32'(max_ad[1]), 32'd8191);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
